// File: rtl/dsp_mac_pipe_if.sv
// dsp_mac_pipe_if: sample/result bundle for one MAC slice.
//   master : drives the sample side (ce, in_valid, operands, opmode) and
//            observes the result side.
//   slave  : the slice itself; consumes the sample side and drives
//            out_valid, p, pcout, bcout, carryout, ovf, ovf_sticky.
interface dsp_mac_pipe_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
);
  logic                 ce;
  logic                 in_valid;
  logic signed [AW-1:0] a;
  logic signed [BW-1:0] b;
  logic signed [BW-1:0] d;
  logic signed [PW-1:0] c;
  logic signed [PW-1:0] pcin;
  logic                 carryin;
  logic [7:0]           opmode;
  logic                 out_valid;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] pcout;
  logic signed [BW-1:0] bcout;
  logic                 carryout;
  logic                 ovf;
  logic                 ovf_sticky;

  modport master (
    output ce, in_valid, a, b, d, c, pcin, carryin, opmode,
    input  out_valid, p, pcout, bcout, carryout, ovf, ovf_sticky
  );

  modport slave (
    input  ce, in_valid, a, b, d, c, pcin, carryin, opmode,
    output out_valid, p, pcout, bcout, carryout, ovf, ovf_sticky
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: parametrised DSP slice. Signed pre-adder (D+/-B), AWxBW
// multiplier with optional pipeline register, PW-bit post-adder /
// accumulator with optional saturation, overflow and sticky overflow.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every register
//   bus   : dsp_mac_pipe_if.slave (sample in, result out, ce stall)
// Latency in_valid -> out_valid is 2+MREG cycles with ce held high.
module dsp_mac_pipe #(
  parameter int AW     = 18,
  parameter int BW     = 18,
  parameter int PW     = 48,
  parameter int MREG   = 1,
  parameter int SAT_EN = 0
) (
  input logic           clk,
  input logic           rst_n,
  dsp_mac_pipe_if.slave bus
);
  localparam int MW = AW + BW;

  if (PW < MW + 1) begin : g_width_check
    $error("dsp_mac_pipe: PW must be at least AW+BW+1");
  end

  // Stage 1: operand capture
  logic signed [AW-1:0] a1;
  logic signed [BW-1:0] b1, d1;
  logic signed [PW-1:0] c1, pcin1;
  logic                 cin1;
  logic [7:0]           op1;
  logic                 v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1    <= '0;
      b1    <= '0;
      d1    <= '0;
      c1    <= '0;
      pcin1 <= '0;
      cin1  <= 1'b0;
      op1   <= '0;
      v1    <= 1'b0;
    end else if (bus.ce) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        a1    <= bus.a;
        b1    <= bus.b;
        d1    <= bus.d;
        c1    <= bus.c;
        pcin1 <= bus.pcin;
        cin1  <= bus.carryin;
        op1   <= bus.opmode;
      end
    end
  end

  // Pre-adder wraps at BW bits; operands are sign-extended to MW so the
  // product keeps full precision.
  logic signed [BW-1:0] pre, preb;
  logic signed [MW-1:0] a_ext, b_ext, prod;

  always_comb begin
    pre   = op1[4] ? (d1 - b1) : (d1 + b1);
    preb  = op1[5] ? pre : b1;
    a_ext = {{BW{a1[AW-1]}}, a1};
    b_ext = {{AW{preb[BW-1]}}, preb};
    prod  = a_ext * b_ext;
  end

  // Stage 2: optional multiplier register; *_s is whatever feeds stage 3.
  logic signed [MW-1:0] m_s;
  logic signed [PW-1:0] c_s, pcin_s;
  logic                 cin_s;
  logic [7:0]           op_s;
  logic                 v_s;

  if (MREG != 0) begin : g_mreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_s    <= '0;
        c_s    <= '0;
        pcin_s <= '0;
        cin_s  <= 1'b0;
        op_s   <= '0;
        v_s    <= 1'b0;
      end else if (bus.ce) begin
        v_s <= v1;
        if (v1) begin
          m_s    <= prod;
          c_s    <= c1;
          pcin_s <= pcin1;
          cin_s  <= cin1;
          op_s   <= op1;
        end
      end
    end
  end else begin : g_no_mreg
    assign m_s    = prod;
    assign c_s    = c1;
    assign pcin_s = pcin1;
    assign cin_s  = cin1;
    assign op_s   = op1;
    assign v_s    = v1;
  end

  // Stage 3: post-adder / accumulator
  logic signed [PW-1:0] p_r, p_fb, x_sel, z_sel, p_next;
  logic [PW:0]          sum_u, sum_s, cin_ext;
  logic                 ovf_next;
  logic                 out_valid_r, carryout_r, ovf_r, ovf_sticky_r;

  always_comb begin
    // A clear sample sees P as zero wherever P is selected.
    p_fb = op_s[7] ? '0 : p_r;
    case (op_s[1:0])
      2'd0:    x_sel = '0;
      2'd1:    x_sel = {{(PW-MW){m_s[MW-1]}}, m_s};
      2'd2:    x_sel = p_fb;
      default: x_sel = c_s;
    endcase
    case (op_s[3:2])
      2'd0:    z_sel = '0;
      2'd1:    z_sel = pcin_s;
      2'd2:    z_sel = p_fb;
      default: z_sel = c_s;
    endcase
    cin_ext = {{PW{1'b0}}, cin_s};
    // sum_u zero-extends for the carry/borrow bit, sum_s sign-extends so
    // bits PW and PW-1 disagree exactly on signed overflow.
    if (op_s[6]) begin
      sum_u = {1'b0, z_sel} - {1'b0, x_sel} - cin_ext;
      sum_s = {z_sel[PW-1], z_sel} - {x_sel[PW-1], x_sel} - cin_ext;
    end else begin
      sum_u = {1'b0, z_sel} + {1'b0, x_sel} + cin_ext;
      sum_s = {z_sel[PW-1], z_sel} + {x_sel[PW-1], x_sel} + cin_ext;
    end
    ovf_next = sum_s[PW] ^ sum_s[PW-1];
    if (ovf_next && (SAT_EN != 0))
      p_next = sum_s[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    else
      p_next = sum_s[PW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r          <= '0;
      out_valid_r  <= 1'b0;
      carryout_r   <= 1'b0;
      ovf_r        <= 1'b0;
      ovf_sticky_r <= 1'b0;
    end else if (bus.ce) begin
      out_valid_r <= v_s;
      if (v_s) begin
        p_r        <= p_next;
        carryout_r <= sum_u[PW];
        ovf_r      <= ovf_next;
        // A clear sample restarts the sticky flag from its own overflow.
        if (op_s[7])
          ovf_sticky_r <= ovf_next;
        else if (ovf_next)
          ovf_sticky_r <= 1'b1;
      end
    end
  end

  assign bus.p          = p_r;
  assign bus.pcout      = p_r;
  assign bus.bcout      = b1;
  assign bus.out_valid  = out_valid_r;
  assign bus.carryout   = carryout_r;
  assign bus.ovf        = ovf_r;
  assign bus.ovf_sticky = ovf_sticky_r;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
module tb_dsp_mac_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // m_if: 18x18 -> 48, MREG=1, wrap
  // s_if: 8x8 -> 20, MREG=1, saturate
  // w_if: 8x8 -> 20, MREG=0, wrap
  dsp_mac_pipe_if #(.AW(18), .BW(18), .PW(48)) m_if ();
  dsp_mac_pipe_if #(.AW(8),  .BW(8),  .PW(20)) s_if ();
  dsp_mac_pipe_if #(.AW(8),  .BW(8),  .PW(20)) w_if ();

  dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .MREG(1), .SAT_EN(0)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(m_if.slave));
  dsp_mac_pipe #(.AW(8), .BW(8), .PW(20), .MREG(1), .SAT_EN(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave));
  dsp_mac_pipe #(.AW(8), .BW(8), .PW(20), .MREG(0), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(w_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_m(input bit v, input int a, input int b, input int d,
                         input int c, input bit cin, input logic [7:0] op);
    m_if.in_valid = v;
    m_if.a        = 18'(a);
    m_if.b        = 18'(b);
    m_if.d        = 18'(d);
    m_if.c        = 48'(c);
    m_if.pcin     = '0;
    m_if.carryin  = cin;
    m_if.opmode   = op;
  endtask

  task automatic drive_s(input bit v, input int c, input logic [7:0] op);
    s_if.in_valid = v;  w_if.in_valid = v;
    s_if.a = '0;        w_if.a = '0;
    s_if.b = '0;        w_if.b = '0;
    s_if.d = '0;        w_if.d = '0;
    s_if.c = 20'(c);    w_if.c = 20'(c);
    s_if.pcin = '0;     w_if.pcin = '0;
    s_if.carryin = 1'b0; w_if.carryin = 1'b0;
    s_if.opmode = op;   w_if.opmode = op;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_if.p !== 48'sd0) begin failures++; $display("FAIL reset_p: got %0d expected 0", m_if.p); end
    checks++; if (m_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", m_if.out_valid); end
    checks++; if (m_if.bcout !== 18'sd0) begin failures++; $display("FAIL reset_bcout: got %0d expected 0", m_if.bcout); end
    checks++; if (s_if.ovf_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky: got %b expected 0", s_if.ovf_sticky); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_preadd();
    @(negedge clk); drive_m(1, 8, 7, 6, 0, 0, 8'h21);
    @(negedge clk); m_if.in_valid = 1'b0;
    checks++; if (m_if.out_valid !== 1'b0) begin failures++; $display("FAIL preadd_valid_c1: got %b expected 0", m_if.out_valid); end
    @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b0) begin failures++; $display("FAIL preadd_valid_c2: got %b expected 0", m_if.out_valid); end
    @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b1) begin failures++; $display("FAIL preadd_valid_c3: got %b expected 1", m_if.out_valid); end
    checks++; if (m_if.p !== 48'sd104) begin failures++; $display("FAIL preadd_p: got %0d expected 104", m_if.p); end
    checks++; if (m_if.pcout !== 48'sd104) begin failures++; $display("FAIL preadd_pcout: got %0d expected 104", m_if.pcout); end
    checks++; if (m_if.ovf !== 1'b0) begin failures++; $display("FAIL preadd_ovf: got %b expected 0", m_if.ovf); end
    checks++; if (m_if.carryout !== 1'b0) begin failures++; $display("FAIL preadd_carry: got %b expected 0", m_if.carryout); end
    @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b0) begin failures++; $display("FAIL preadd_valid_c4: got %b expected 0", m_if.out_valid); end
    checks++; if (m_if.p !== 48'sd104) begin failures++; $display("FAIL preadd_hold: got %0d expected 104", m_if.p); end
  endtask

  task automatic test_presub_postsub();
    @(negedge clk); drive_m(1, 8, 7, 6, 0, 0, 8'h31);
    @(negedge clk); drive_m(1, 8, 7, 6, 9, 1, 8'h4D);
    @(negedge clk); m_if.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_if.p !== -48'sd8) begin failures++; $display("FAIL presub_p: got %0d expected -8", m_if.p); end
    checks++; if (m_if.out_valid !== 1'b1) begin failures++; $display("FAIL presub_valid: got %b expected 1", m_if.out_valid); end
    @(negedge clk);
    checks++; if (m_if.p !== -48'sd48) begin failures++; $display("FAIL postsub_p: got %0d expected -48", m_if.p); end
    checks++; if (m_if.carryout !== 1'b1) begin failures++; $display("FAIL postsub_borrow: got %b expected 1", m_if.carryout); end
    checks++; if (m_if.ovf !== 1'b0) begin failures++; $display("FAIL postsub_ovf: got %b expected 0", m_if.ovf); end
  endtask

  task automatic test_accumulate();
    logic signed [47:0] exp_p;
    @(negedge clk); drive_m(1, 2, 3, 0, 0, 0, 8'h80);
    @(negedge clk); m_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_if.p !== 48'sd0) begin failures++; $display("FAIL acc_zero: got %0d expected 0", m_if.p); end
    for (int k = 1; k <= 4; k++) begin
      exp_p = 48'(6 * k);
      @(negedge clk); drive_m(1, 2, 3, 0, 0, 0, 8'h09);
      @(negedge clk); m_if.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (m_if.p !== exp_p || m_if.out_valid !== 1'b1) begin failures++; $display("FAIL acc_step%0d: got %0d/%b expected %0d/1", k, m_if.p, m_if.out_valid, exp_p); end
      @(negedge clk);
      checks++; if (m_if.p !== exp_p || m_if.out_valid !== 1'b0) begin failures++; $display("FAIL acc_gap%0d: got %0d/%b expected %0d/0", k, m_if.p, m_if.out_valid, exp_p); end
    end
    @(negedge clk); drive_m(1, 2, 3, 0, 0, 0, 8'h89);
    @(negedge clk); m_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_if.p !== 48'sd6) begin failures++; $display("FAIL acc_clear: got %0d expected 6", m_if.p); end
  endtask

  task automatic test_stall();
    @(negedge clk); drive_m(1, 2, 5, 0, 0, 0, 8'h89);
    @(negedge clk); drive_m(1, 2, 4, 0, 0, 0, 8'h09);
    @(negedge clk); drive_m(1, 2, 6, 0, 0, 0, 8'h09); m_if.ce = 1'b0;
    @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b0 || m_if.p !== 48'sd6) begin failures++; $display("FAIL stall_freeze1: got %b/%0d expected 0/6", m_if.out_valid, m_if.p); end
    checks++; if (m_if.bcout !== 18'sd4) begin failures++; $display("FAIL stall_bcout1: got %0d expected 4", m_if.bcout); end
    @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b0 || m_if.p !== 48'sd6) begin failures++; $display("FAIL stall_freeze2: got %b/%0d expected 0/6", m_if.out_valid, m_if.p); end
    checks++; if (m_if.bcout !== 18'sd4) begin failures++; $display("FAIL stall_bcout2: got %0d expected 4", m_if.bcout); end
    m_if.ce = 1'b1;
    @(negedge clk); m_if.in_valid = 1'b0;
    checks++; if (m_if.out_valid !== 1'b1 || m_if.p !== 48'sd10) begin failures++; $display("FAIL stall_r0: got %b/%0d expected 1/10", m_if.out_valid, m_if.p); end
    checks++; if (m_if.bcout !== 18'sd6) begin failures++; $display("FAIL stall_bcout3: got %0d expected 6", m_if.bcout); end
    @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b1 || m_if.p !== 48'sd18) begin failures++; $display("FAIL stall_r1: got %b/%0d expected 1/18", m_if.out_valid, m_if.p); end
    @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b1 || m_if.p !== 48'sd30) begin failures++; $display("FAIL stall_r2: got %b/%0d expected 1/30", m_if.out_valid, m_if.p); end
    @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b0 || m_if.p !== 48'sd30) begin failures++; $display("FAIL stall_end: got %b/%0d expected 0/30", m_if.out_valid, m_if.p); end
  endtask

  task automatic test_saturate();
    @(negedge clk); drive_s(1, 262144, 8'h8B);
    @(negedge clk); drive_s(1, 262144, 8'h0B);
    checks++; if (w_if.out_valid !== 1'b0) begin failures++; $display("FAIL wrap_valid_c1: got %b expected 0", w_if.out_valid); end
    @(negedge clk); s_if.in_valid = 1'b0; w_if.in_valid = 1'b0;
    checks++; if (w_if.out_valid !== 1'b1 || w_if.p !== 20'sd262144) begin failures++; $display("FAIL wrap_first: got %b/%0d expected 1/262144", w_if.out_valid, w_if.p); end
    checks++; if (s_if.out_valid !== 1'b0) begin failures++; $display("FAIL sat_valid_c2: got %b expected 0", s_if.out_valid); end
    @(negedge clk);
    checks++; if (w_if.p !== 20'sh80000 || w_if.ovf !== 1'b1) begin failures++; $display("FAIL wrap_ovf: got %0d/%b expected -524288/1", w_if.p, w_if.ovf); end
    checks++; if (w_if.ovf_sticky !== 1'b1) begin failures++; $display("FAIL wrap_sticky: got %b expected 1", w_if.ovf_sticky); end
    checks++; if (s_if.p !== 20'sd262144 || s_if.ovf !== 1'b0 || s_if.ovf_sticky !== 1'b0) begin failures++; $display("FAIL sat_first: got %0d/%b/%b expected 262144/0/0", s_if.p, s_if.ovf, s_if.ovf_sticky); end
    @(negedge clk);
    checks++; if (s_if.p !== 20'sh7FFFF || s_if.ovf !== 1'b1) begin failures++; $display("FAIL sat_max: got %0d/%b expected 524287/1", s_if.p, s_if.ovf); end
    checks++; if (s_if.ovf_sticky !== 1'b1) begin failures++; $display("FAIL sat_sticky: got %b expected 1", s_if.ovf_sticky); end
    @(negedge clk); drive_s(1, 262144, 8'h8B);
    checks++; if (s_if.ovf_sticky !== 1'b1 || s_if.out_valid !== 1'b0) begin failures++; $display("FAIL sat_sticky_hold: got %b/%b expected 1/0", s_if.ovf_sticky, s_if.out_valid); end
    @(negedge clk); s_if.in_valid = 1'b0; w_if.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (w_if.ovf_sticky !== 1'b0 || w_if.p !== 20'sd262144) begin failures++; $display("FAIL wrap_clear: got %b/%0d expected 0/262144", w_if.ovf_sticky, w_if.p); end
    checks++; if (s_if.ovf_sticky !== 1'b1) begin failures++; $display("FAIL sat_clear_early: got %b expected 1", s_if.ovf_sticky); end
    @(negedge clk);
    checks++; if (s_if.ovf_sticky !== 1'b0 || s_if.p !== 20'sd262144) begin failures++; $display("FAIL sat_clear: got %b/%0d expected 0/262144", s_if.ovf_sticky, s_if.p); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); drive_m(1, 8, 7, 6, 9, 1, 8'h4D); drive_s(1, 262144, 8'h8F);
    @(negedge clk); m_if.in_valid = 1'b0; s_if.in_valid = 1'b0; w_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); drive_m(1, 2, 3, 0, 0, 0, 8'h09);
    checks++; if (s_if.ovf_sticky !== 1'b1 || s_if.p !== 20'sh7FFFF) begin failures++; $display("FAIL clear_ovf_sticky: got %b/%0d expected 1/524287", s_if.ovf_sticky, s_if.p); end
    checks++; if (w_if.ovf_sticky !== 1'b1 || w_if.p !== 20'sh80000) begin failures++; $display("FAIL wrap_clear_ovf: got %b/%0d expected 1/-524288", w_if.ovf_sticky, w_if.p); end
    checks++; if (m_if.p !== -48'sd48 || m_if.carryout !== 1'b1) begin failures++; $display("FAIL pre_reset_main: got %0d/%b expected -48/1", m_if.p, m_if.carryout); end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (m_if.p !== 48'sd0 || m_if.out_valid !== 1'b0) begin failures++; $display("FAIL async_p_valid: got %0d/%b expected 0/0", m_if.p, m_if.out_valid); end
    checks++; if (m_if.carryout !== 1'b0 || m_if.bcout !== 18'sd0) begin failures++; $display("FAIL async_carry_bcout: got %b/%0d expected 0/0", m_if.carryout, m_if.bcout); end
    checks++; if (s_if.ovf_sticky !== 1'b0 || w_if.ovf_sticky !== 1'b0) begin failures++; $display("FAIL async_sticky: got %b/%b expected 0/0", s_if.ovf_sticky, w_if.ovf_sticky); end
    #1 rst_n = 1'b1; m_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (m_if.out_valid !== 1'b0 || m_if.p !== 48'sd0) begin failures++; $display("FAIL restart_empty%0d: got %b/%0d expected 0/0", i, m_if.out_valid, m_if.p); end
    end
    @(negedge clk); drive_m(1, 2, 3, 0, 0, 0, 8'h09);
    @(negedge clk); m_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_if.out_valid !== 1'b1 || m_if.p !== 48'sd6) begin failures++; $display("FAIL restart_first: got %b/%0d expected 1/6", m_if.out_valid, m_if.p); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    m_if.ce  = 1'b1;
    s_if.ce  = 1'b1;
    w_if.ce  = 1'b1;
    drive_m(0, 0, 0, 0, 0, 0, 8'h00);
    drive_s(0, 0, 8'h00);
    test_reset();
    test_preadd();
    test_presub_postsub();
    test_accumulate();
    test_stall();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
- Parametrised successor to the fixed-width DSP slice: signed pre-adder, multiplier and post-adder/accumulator with generic widths and an optional multiplier pipeline stage.
- Adds features the fixed slice lacks: valid-token tracking through the pipe, a global stall, optional saturation, an overflow flag, a sticky overflow flag and an accumulator clear.
- Sits in the datapath wherever filters and MAC chains need one slice; PCIN/PCOUT cascade slice-to-slice.

Parameters:
- AW, 18, width of A (signed).
- BW, 18, width of B and D (signed).
- PW, 48, width of C, PCIN, P and PCOUT (signed). Elaboration must fail if PW < AW+BW+1.
- MREG, 1, 1 = registered multiplier stage (latency 3); 0 = bypassed (latency 2).
- SAT_EN, 0, 1 = saturate P on signed overflow; 0 = wrap.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- CE  in  1  global clock enable; 0 stalls every register.
- IN_VALID  in  1  input sample valid.
- A  in  AW  multiplier operand.
- B  in  BW  pre-adder operand.
- D  in  BW  pre-adder operand.
- C  in  PW  post-adder operand.
- PCIN  in  PW  cascade input.
- CARRYIN  in  1  post-adder carry.
- OPMODE  in  8  operation select, captured with the sample.
- OUT_VALID  out  1  P holds a new result.
- P  out  PW  result register.
- PCOUT  out  PW  equals P.
- BCOUT  out  BW  stage-1 B register.
- CARRYOUT  out  1  registered post-adder carry/borrow.
- OVF  out  1  signed overflow on the current result.
- OVF_STICKY  out  1  latched OVF.

Behaviour:
- Reset: RSTN low clears every register immediately, without waiting for a clock edge. All outputs read 0.
- OPMODE fields:
  - [1:0] X select: 0 = zero, 1 = M sign-extended to PW, 2 = P, 3 = C.
  - [3:2] Z select: 0 = zero, 1 = PCIN, 2 = P, 3 = C.
  - [4] pre-adder subtract: PRE = D-B when 1, D+B when 0.
  - [5] pre-adder enable: 1 = PRE, 0 = B.
  - [6] post-adder subtract: 1 = Z-(X+CIN), 0 = Z+X+CIN.
  - [7] clear: any P selection reads as 0 for this sample, and OVF_STICKY clears.
- Stage 1:
  - When CE=1 and IN_VALID=1, register A, B, D, C, PCIN, CARRYIN and OPMODE.
  - v1 <= IN_VALID whenever CE=1.
- Stage 2 (MREG=1):
  - When CE=1 and v1=1, M <= A1*PREB, where PREB is the pre-adder output or B1 per OPMODE[5].
  - C, PCIN, CARRYIN and OPMODE travel alongside M.
  - v2 <= v1 when CE=1.
- Stage 3:
  - When CE=1 and the last valid stage is 1, P, CARRYOUT and OVF update.
  - Otherwise P holds. This is what makes accumulation count only valid samples.
  - OUT_VALID <= the last valid stage when CE=1.
- Latency: IN_VALID to OUT_VALID is 2+MREG cycles with CE held high. Each CE=0 cycle adds one cycle; all state freezes, including OUT_VALID.
- Pre-adder: BW-bit two's complement; wraps on overflow.
- Multiplier: full AW+BW-bit signed product.
- Post-adder:
  - Computed at PW+1 bits.
  - CARRYOUT = bit PW of the unsigned PW+1-bit sum or difference.
  - OVF = signed overflow of the PW-bit result.
  - With SAT_EN=1 and OVF=1, P = +max (positive overflow) or -max-1 (negative overflow). Otherwise P wraps.
- OVF_STICKY:
  - Sets on any registered OVF.
  - Clears only on RSTN or on an OPMODE[7] sample reaching stage 3.
  - If that clear sample itself overflows, OVF_STICKY ends at 1.
- Simultaneous events:
  - CE=0 overrides IN_VALID; the sample is lost and the source must hold it.
  - RSTN overrides everything.
- Back-to-back valid samples are accepted every cycle. Feedback of P uses the P register value at the capture edge, i.e. the previous result.

Test Plan:
- MREG=1, A=8, B=7, D=6, OPMODE=0x21 (pre-add, X=M, Z=0), one valid pulse -> OUT_VALID high exactly 3 cycles later, P=104, OVF=0.
- Same operands, OPMODE=0x31 (pre-sub) -> P=-8. Then OPMODE=0x4D (no pre-add, X=M, Z=C, post-sub), C=9, CARRYIN=1 -> P=9-(56+1)=-48.
- A=2, B=3, OPMODE=0x09 (X=M, Z=P), four valid samples with idle gaps -> P=6, 12, 18, 24 and holds during gaps. Then a sample with OPMODE=0x89 -> P=6.
- AW=BW=8, PW=20, SAT_EN=1, X=C, Z=P, C=262144, two valid samples -> P=262144, then P=524287 with OVF=1 and OVF_STICKY=1. Same run with SAT_EN=0 -> P=-524288.
- CE=0 for 2 cycles mid-stream of 3 samples -> P, OUT_VALID and BCOUT frozen; results identical, each delayed by 2 cycles.
- RSTN pulsed low between clock edges mid-accumulation -> P, OUT_VALID, CARRYOUT and OVF_STICKY read 0 before the next edge; the pipeline restarts empty.
